// File: rtl/disp_pkg.sv
// Shared types and sizes for the register display scanner.
package disp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SNAP  = 2'd1,
      DRIVE = 2'd2,
      BLANK = 2'd3
   } state_t;

   localparam int NUM_ROWS  = 8;
   localparam int ROW_W     = 64;
   localparam int ROW_IDX_W = 3;

endpackage

// File: rtl/reg_display_scanner_tick_prescaler.sv
// Free-running scan-tick prescaler; tick marks the last cycle of each period.
module tick_prescaler #(
   parameter int TICK_DIV = 50000
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == CNT_LAST);

   // Next count: hold at zero while cleared, wrap after the last cycle.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (clr || (cnt_q == CNT_LAST)) begin
         cnt_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/reg_display_scanner.sv
// Multiplexed row display scanner for the eight 64-bit register taps.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | scanning stopped, outputs blank
// SNAP  | one cycle: capture R0..R7 (unless hold), restart at row 0
// DRIVE | active row driven for DWELL_TICKS ticks
// BLANK | row gap for BLANK_TICKS ticks (skipped when BLANK_TICKS = 0)
module reg_display_scanner
   import disp_pkg::*;
#(
   parameter int TICK_DIV    = 50000,
   parameter int DWELL_TICKS = 4,
   parameter int BLANK_TICKS = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                hold,
   input  logic [ROW_W-1:0]    R0,
   input  logic [ROW_W-1:0]    R1,
   input  logic [ROW_W-1:0]    R2,
   input  logic [ROW_W-1:0]    R3,
   input  logic [ROW_W-1:0]    R4,
   input  logic [ROW_W-1:0]    R5,
   input  logic [ROW_W-1:0]    R6,
   input  logic [ROW_W-1:0]    R7,
   output logic [NUM_ROWS-1:0] row_sel,
   output logic [ROW_W-1:0]    row_data,
   output logic                row_valid,
   output logic                frame_done
);

   localparam logic [15:0] DWELL_LAST = 16'(DWELL_TICKS - 1);
   localparam logic [15:0] BLANK_LAST = 16'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
   localparam bit          NO_BLANK   = (BLANK_TICKS == 0);
   localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(NUM_ROWS - 1);

   logic [ROW_W-1:0] r_in [NUM_ROWS];

   assign r_in[0] = R0;
   assign r_in[1] = R1;
   assign r_in[2] = R2;
   assign r_in[3] = R3;
   assign r_in[4] = R4;
   assign r_in[5] = R5;
   assign r_in[6] = R6;
   assign r_in[7] = R7;

   state_t                 state_q, state_d;
   logic [ROW_IDX_W-1:0]   row_idx_q, row_idx_d;
   logic [15:0]            dwell_q, dwell_d;
   logic [ROW_W-1:0]       snap_q [NUM_ROWS];
   logic [ROW_W-1:0]       snap_d [NUM_ROWS];
   logic [NUM_ROWS-1:0]    row_sel_q, row_sel_d;
   logic [ROW_W-1:0]       row_data_q, row_data_d;
   logic                   row_valid_q, row_valid_d;
   logic                   frame_done_q, frame_done_d;
   logic                   row_end;
   logic                   tick;
   logic                   div_clr;

   // The prescaler restarts so every DRIVE after SNAP begins a fresh tick period.
   assign div_clr = (state_q == IDLE) || (state_q == SNAP) || !enable;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clock (clock),
      .reset (reset),
      .clr   (div_clr),
      .tick  (tick)
   );

   // Snapshot bank refresh: only in SNAP, and only when not frozen.
   always_comb begin
      snap_d = snap_q;
      if ((state_q == SNAP) && enable && !hold) begin
         snap_d = r_in;
      end
   end

   // Next-state logic; the same counter times both dwell and blank phases.
   always_comb begin
      state_d      = state_q;
      row_idx_d    = row_idx_q;
      dwell_d      = dwell_q;
      frame_done_d = 1'b0;
      row_end      = 1'b0;

      if (!enable) begin
         state_d   = IDLE;
         row_idx_d = '0;
         dwell_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = SNAP;
            end
            SNAP: begin
               row_idx_d = '0;
               dwell_d   = '0;
               state_d   = DRIVE;
            end
            DRIVE: begin
               if (tick) begin
                  if (dwell_q == DWELL_LAST) begin
                     dwell_d = '0;
                     if (NO_BLANK) begin
                        row_end = 1'b1;
                     end else begin
                        state_d = BLANK;
                     end
                  end else begin
                     dwell_d = dwell_q + 16'd1;
                  end
               end
            end
            BLANK: begin
               if (tick) begin
                  if (dwell_q == BLANK_LAST) begin
                     dwell_d = '0;
                     row_end = 1'b1;
                  end else begin
                     dwell_d = dwell_q + 16'd1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         if (row_end) begin
            if (row_idx_q == LAST_ROW) begin
               frame_done_d = 1'b1;
               state_d      = SNAP;
            end else begin
               row_idx_d = row_idx_q + ROW_IDX_W'(1);
               state_d   = DRIVE;
            end
         end
      end
   end

   // Output decode from the upcoming state so outputs line up with it.
   always_comb begin
      row_sel_d   = '0;
      row_data_d  = '0;
      row_valid_d = 1'b0;
      if (state_d == DRIVE) begin
         row_sel_d   = NUM_ROWS'(1) << row_idx_d;
         row_data_d  = snap_d[row_idx_d];
         row_valid_d = 1'b1;
      end
   end

   // State, counters, snapshot bank and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         row_idx_q    <= '0;
         dwell_q      <= '0;
         row_sel_q    <= '0;
         row_data_q   <= '0;
         row_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < NUM_ROWS; i++) begin
            snap_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         row_idx_q    <= row_idx_d;
         dwell_q      <= dwell_d;
         row_sel_q    <= row_sel_d;
         row_data_q   <= row_data_d;
         row_valid_q  <= row_valid_d;
         frame_done_q <= frame_done_d;
         snap_q       <= snap_d;
      end
   end

   assign row_sel    = row_sel_q;
   assign row_data   = row_data_q;
   assign row_valid  = row_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_reg_display_scanner.sv
// Directed bench for reg_display_scanner: TICK_DIV=2, DWELL=2, BLANK=1
// (49-cycle frame) plus a BLANK=0 instance (33-cycle frame).
module tb_reg_display_scanner;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic        hold;
   logic [63:0] r [8];
   logic [63:0] expv [8];

   logic [7:0]  row_sel,  z_row_sel;
   logic [63:0] row_data, z_row_data;
   logic        row_valid, z_row_valid;
   logic        frame_done, z_frame_done;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   reg_display_scanner #(.TICK_DIV(2), .DWELL_TICKS(2), .BLANK_TICKS(1)) dut (
      .clock(clock), .reset(reset), .enable(enable), .hold(hold),
      .R0(r[0]), .R1(r[1]), .R2(r[2]), .R3(r[3]),
      .R4(r[4]), .R5(r[5]), .R6(r[6]), .R7(r[7]),
      .row_sel(row_sel), .row_data(row_data),
      .row_valid(row_valid), .frame_done(frame_done)
   );

   reg_display_scanner #(.TICK_DIV(2), .DWELL_TICKS(2), .BLANK_TICKS(0)) dut0 (
      .clock(clock), .reset(reset), .enable(enable), .hold(hold),
      .R0(r[0]), .R1(r[1]), .R2(r[2]), .R3(r[3]),
      .R4(r[4]), .R5(r[5]), .R6(r[6]), .R7(r[7]),
      .row_sel(z_row_sel), .row_data(z_row_data),
      .row_valid(z_row_valid), .frame_done(z_frame_done)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_blank(input string tag);
      chk({tag, "_sel"},   64'(row_sel),    64'd0);
      chk({tag, "_data"},  row_data,        64'd0);
      chk({tag, "_valid"}, 64'(row_valid),  64'd0);
      chk({tag, "_fd"},    64'(frame_done), 64'd0);
   endtask

   // Call with the next posedge entering SNAP. t=0 is the SNAP cycle; row k is
   // driven on t = 1+6k .. 4+6k and blanked on t = 5+6k .. 6+6k.
   // stop_kind: 0 = drop enable after sampling stop_t, 1 = assert reset.
   task automatic run_frame(input int fn, input bit fd_exp, input int chg_t,
                            input int stop_t, input int stop_kind);
      logic [7:0]  es;
      logic [63:0] ed;
      logic        ev, ef;
      int          u, row;
      for (int t = 0; t < 49; t++) begin
         @(negedge clock);
         es = 8'h00; ed = 64'd0; ev = 1'b0; ef = 1'b0;
         if (t == 0) begin
            ef = fd_exp;
         end else begin
            u   = t - 1;
            row = u / 6;
            if ((u % 6) < 4) begin
               es = 8'h01;
               es = es << row;
               ed = expv[row];
               ev = 1'b1;
            end
         end
         chk($sformatf("f%0d_t%0d_sel", fn, t),   64'(row_sel),    64'(es));
         chk($sformatf("f%0d_t%0d_data", fn, t),  row_data,        ed);
         chk($sformatf("f%0d_t%0d_valid", fn, t), 64'(row_valid),  64'(ev));
         chk($sformatf("f%0d_t%0d_fd", fn, t),    64'(frame_done), 64'(ef));
         if (t == chg_t) r[3] = 64'hDEADBEEF_00000000;
         if (t == stop_t) begin
            if (stop_kind == 0) enable = 1'b0;
            else                reset  = 1'b1;
            return;
         end
      end
   endtask

   // BLANK_TICKS = 0 instance: row k driven on t = 1+4k .. 4+4k, 33-cycle frame.
   task automatic run_frame0(input int fn, input bit fd_exp);
      logic [7:0]  es;
      logic [63:0] ed;
      logic        ev, ef;
      int          row;
      for (int t = 0; t < 33; t++) begin
         @(negedge clock);
         es = 8'h00; ed = 64'd0; ev = 1'b0; ef = 1'b0;
         if (t == 0) begin
            ef = fd_exp;
         end else begin
            row = (t - 1) / 4;
            es  = 8'h01;
            es  = es << row;
            ed  = expv[row];
            ev  = 1'b1;
         end
         chk($sformatf("z%0d_t%0d_sel", fn, t),   64'(z_row_sel),    64'(es));
         chk($sformatf("z%0d_t%0d_data", fn, t),  z_row_data,        ed);
         chk($sformatf("z%0d_t%0d_valid", fn, t), 64'(z_row_valid),  64'(ev));
         chk($sformatf("z%0d_t%0d_fd", fn, t),    64'(z_frame_done), 64'(ef));
      end
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      hold   = 1'b0;
      for (int k = 0; k < 8; k++) begin
         r[k]    = 64'(k) + (64'(k) << 60);
         expv[k] = r[k];
      end
      repeat (3) @(negedge clock);

      // Reset state of both instances.
      chk_blank("rst");
      chk("rst0_sel",   64'(z_row_sel),    64'd0);
      chk("rst0_data",  z_row_data,        64'd0);
      chk("rst0_valid", 64'(z_row_valid),  64'd0);
      chk("rst0_fd",    64'(z_frame_done), 64'd0);

      // Basic scan, then continuous frames with a mid-frame R3 change.
      reset  = 1'b0;
      enable = 1'b1;
      run_frame(1, 1'b0, -1, -1, 0);
      run_frame(2, 1'b1, 20, -1, 0);
      expv[3] = 64'hDEADBEEF_00000000;
      run_frame(3, 1'b1, -1, -1, 0);

      // hold over SNAP: frame 4 repeats frame 3 data; frame 5 picks up new R.
      hold = 1'b1;
      for (int k = 0; k < 8; k++) r[k] = 64'hA5A5_0000_0000_0000 | 64'(k * 17);
      run_frame(4, 1'b1, -1, -1, 0);
      hold = 1'b0;
      for (int k = 0; k < 8; k++) expv[k] = r[k];
      run_frame(5, 1'b1, -1, -1, 0);

      // enable dropped while row 5 drives.
      run_frame(6, 1'b1, -1, 32, 0);
      @(negedge clock);
      chk_blank("dis1");
      @(negedge clock);
      chk_blank("dis2");
      enable = 1'b1;
      run_frame(7, 1'b0, -1, -1, 0);

      // reset during BLANK of row 2; hold over the following SNAP exposes the
      // cleared snapshot bank.
      run_frame(8, 1'b1, -1, 17, 1);
      @(negedge clock);
      chk_blank("rstmid");
      reset = 1'b0;
      hold  = 1'b1;
      for (int k = 0; k < 8; k++) expv[k] = 64'd0;
      run_frame(9, 1'b0, -1, -1, 0);
      hold = 1'b0;
      for (int k = 0; k < 8; k++) expv[k] = r[k];
      run_frame(10, 1'b1, -1, -1, 0);

      // BLANK_TICKS = 0 instance from a fresh reset.
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      run_frame0(1, 1'b0);
      run_frame0(2, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
